// File: rtl/dbus_responder.sv
// Single-port 64-bit data-bus responder backed by a word array, with a fixed
// request-to-completion latency and a one-cycle turnaround after every access.
module dbus_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] l_addr;
  logic [2:0]  l_size;
  logic [7:0]  l_strobe;
  logic [63:0] l_data;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0]   a_addr;
  logic [2:0]    a_size;
  logic [7:0]    a_strobe;
  logic [63:0]   a_data;
  logic [63:0]   offset;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          aligned;
  logic          ok;
  logic          fire;
  logic [63:0]   old_word;
  logic [63:0]   merged;

  // The access is evaluated on the edge that enters the final WAIT cycle, so
  // data_ok appears LATENCY cycles after acceptance; with LATENCY=1 that edge is
  // the accepting edge itself and the live request fields are used.
  always_comb begin
    fire = (state == IDLE && req_valid && LATENCY == 1) ||
           (state == WAIT && cnt == 4'd1);
    if (state == IDLE) begin
      a_addr   = req_addr;
      a_size   = req_size;
      a_strobe = req_strobe;
      a_data   = req_data;
    end else begin
      a_addr   = l_addr;
      a_size   = l_size;
      a_strobe = l_strobe;
      a_data   = l_data;
    end
    offset   = a_addr - BASE_ADDR;
    in_range = (a_addr >= BASE_ADDR) && ((offset >> 3) < 64'(DEPTH_WORDS));
    idx      = offset[IW+2:3];
    case (a_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (a_addr[0] == 1'b0);
      3'd2:    aligned = (a_addr[1:0] == 2'b00);
      3'd3:    aligned = (a_addr[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
    ok       = in_range && aligned;
    old_word = mem[idx];
    merged   = old_word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (a_strobe[i]) merged[8*i +: 8] = a_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fire && ok && (a_strobe != '0)) mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_addr_ok <= 1'b0;
      resp_data_ok <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
    end else begin
      resp_addr_ok <= 1'b0;
      resp_data_ok <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_addr       <= req_addr;
            l_size       <= req_size;
            l_strobe     <= req_strobe;
            l_data       <= req_data;
            cnt          <= 4'(LATENCY - 1);
            state        <= WAIT;
            resp_addr_ok <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        resp_data_ok <= 1'b1;
        if (ok) resp_data <= old_word;
        else    resp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboarded random/directed bench for dbus_responder: instance 0 runs with
// LATENCY=2, instance 1 with LATENCY=1; a monitor pops expected responses.
module tb_dbus_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset        [2];
  logic        req_valid    [2];
  logic [63:0] req_addr     [2];
  logic [2:0]  req_size     [2];
  logic [7:0]  req_strobe   [2];
  logic [63:0] req_data     [2];
  logic        resp_addr_ok [2];
  logic        resp_data_ok [2];
  logic [63:0] resp_data    [2];
  logic        resp_err     [2];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ack_cyc [2];

  // expected entry: {data_known, err, data}
  logic [65:0] expq [2][$];
  logic [63:0] mdl   [2][DEPTH];
  bit          known [2][DEPTH];

  dbus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_size(req_size[0]), .req_strobe(req_strobe[0]), .req_data(req_data[0]),
    .resp_addr_ok(resp_addr_ok[0]), .resp_data_ok(resp_data_ok[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]));

  dbus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_size(req_size[1]), .req_strobe(req_strobe[1]), .req_data(req_data[1]),
    .resp_addr_ok(resp_addr_ok[1]), .resp_data_ok(resp_data_ok[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
  endtask

  // Reference model: plain byte-address arithmetic over a word array.
  function automatic logic [65:0] model(input int d, input logic [63:0] a, input logic [2:0] sz,
                                       input logic [7:0] st, input logic [63:0] wd);
    logic [63:0] w;
    logic [63:0] old;
    int          idx;
    bit          care;
    if (a < BASE || (a - BASE) / 8 >= 64'(DEPTH) || sz > 3 || (a % (64'd1 << sz)) != 0)
      return {1'b1, 1'b1, 64'd0};
    idx  = int'((a - BASE) / 8);
    old  = mdl[d][idx];
    care = known[d][idx];
    w    = old;
    for (int b = 0; b < 8; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
    mdl[d][idx] = w;
    if (st == 8'hFF) known[d][idx] = 1'b1;
    return {care, 1'b0, care ? old : 64'd0};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [65:0] e;
      if (resp_addr_ok[d]) ack_cyc[d] = cyc;
      if (resp_data_ok[d]) begin
        if (expq[d].size() == 0) begin
          checks++;
          $display("FAIL unexpected_data_ok dut%0d: got data_ok=1 expected 0 (cycle %0d)", d, cyc);
        end else begin
          e = expq[d].pop_front();
          chk("resp_err", d, 64'(resp_err[d]), 64'(e[64]));
          if (e[65]) chk("resp_data", d, resp_data[d], e[63:0]);
          chk("latency", d, 64'(cyc - ack_cyc[d]), (d == 0) ? 64'd1 : 64'd0);
        end
      end else if (!reset[d]) begin
        chk("idle_data_err_zero", d, {resp_data[d][62:0], resp_err[d]}, 64'd0);
      end
    end
  end

  task automatic xfer(input int d, input logic [63:0] a, input logic [2:0] sz,
                      input logic [7:0] st, input logic [63:0] wd, input bit chg);
    bit got_ack = 0;
    bit got_done = 0;
    expq[d].push_back(model(d, a, sz, st, wd));
    @(negedge clk);
    req_addr[d] = a; req_size[d] = sz; req_strobe[d] = st; req_data[d] = wd;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      if (resp_addr_ok[d] && !got_ack) begin
        got_ack = 1;
        if (chg) begin
          req_addr[d] = a + 64'd8; req_size[d] = 3'd3;
          req_strobe[d] = ~st; req_data[d] = ~wd;
        end
      end
      if (resp_data_ok[d]) got_done = 1;
    end
    req_valid[d] = 1'b0;
    if (!got_done) begin
      checks++;
      $display("FAIL xfer_timeout dut%0d: got no data_ok expected one within 40 cycles", d);
    end
  endtask

  task automatic rand_ops(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] a;
      logic [2:0]  sz;
      logic [7:0]  st;
      logic [63:0] off;
      int r = $urandom % 10;
      sz = ($urandom % 8 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
      off = 64'($urandom % 8);
      if ($urandom % 4 != 0 && sz < 4) off = off & ~((64'd1 << sz) - 1);
      if (r < 8)       a = BASE + 64'($urandom % 16) * 8 + off;
      else if (r == 8) a = BASE - 64'(8 * ($urandom % 4 + 1)) + off;
      else             a = BASE + 64'(DEPTH * 8) + 64'(8 * ($urandom % 8)) + off;
      st = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom);
      xfer(d, a, sz, st, {$urandom, $urandom}, 0);
    end
  endtask

  initial begin
    int dok;
    int acks [2];
    int n;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0;
      req_size[d] = '0; req_strobe[d] = '0; req_data[d] = '0; ack_cyc[d] = 0;
      for (int i = 0; i < DEPTH; i++) begin mdl[d][i] = '0; known[d][i] = 0; end
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_addr_ok", d, 64'(resp_addr_ok[d]), 64'd0);
      chk("reset_data_ok", d, 64'(resp_data_ok[d]), 64'd0);
      chk("reset_data", d, resp_data[d], 64'd0);
      chk("reset_err", d, 64'(resp_err[d]), 64'd0);
      reset[d] = 1'b0;
    end

    for (int w = 0; w < 16; w++) xfer(0, BASE + 64'(w * 8), 3'd3, 8'hFF, {$urandom, $urandom}, 0);
    xfer(0, 64'h8000_0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 0);
    xfer(0, 64'h8000_0008, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_0009, 3'd0, 8'h02, 64'h0000_0000_0000_AB00, 0);
    xfer(0, 64'h8000_0008, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_0004, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_2000, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_0004, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    xfer(0, 64'h8000_1FF8, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
    xfer(0, 64'h8000_0000, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_1FF8, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_0010, 3'd3, 8'hFF, 64'h0000_0000_CAFE_F00D, 1);
    xfer(0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, 0);
    xfer(0, 64'h8000_0018, 3'd3, 8'h00, 64'd0, 0);

    // Abort a write by pulsing reset in the cycle after acceptance.
    @(negedge clk);
    req_addr[0] = 64'h8000_0010; req_size[0] = 3'd3; req_strobe[0] = 8'hFF;
    req_data[0] = 64'h0000_0000_DEAD_BEEF; req_valid[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clk);
      if (resp_addr_ok[0]) n = 1;
    end
    chk("abort_accepted", 0, 64'(n), 64'd1);
    reset[0] = 1'b1; req_valid[0] = 1'b0;
    dok = 0;
    @(negedge clk);
    reset[0] = 1'b0;
    chk("post_reset_addr_ok", 0, 64'(resp_addr_ok[0]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (resp_data_ok[0]) dok++;
      @(negedge clk);
    end
    chk("abort_no_data_ok", 0, 64'(dok), 64'd0);
    xfer(0, 64'h8000_0010, 3'd3, 8'h00, 64'd0, 0);

    rand_ops(0, 80);

    for (int w = 0; w < 16; w++) xfer(1, BASE + 64'(w * 8), 3'd3, 8'hFF, {$urandom, $urandom}, 0);
    expq[1].push_back(model(1, 64'h8000_0008, 3'd3, 8'h00, 64'd0));
    expq[1].push_back(model(1, 64'h8000_0008, 3'd3, 8'h00, 64'd0));
    @(negedge clk);
    req_addr[1] = 64'h8000_0008; req_size[1] = 3'd3; req_strobe[1] = 8'h00;
    req_data[1] = '0; req_valid[1] = 1'b1;
    n = 0; acks[0] = 0; acks[1] = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (resp_addr_ok[1]) begin acks[n] = cyc; n++; end
    end
    req_valid[1] = 1'b0;
    chk("b2b_accepts", 1, 64'(n), 64'd2);
    chk("b2b_period", 1, 64'(acks[1] - acks[0]), 64'd3);
    repeat (2) @(negedge clk);

    rand_ops(1, 60);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("scoreboard_drained", d, 64'(expq[d].size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
